// File: rtl/sseg_scan_decoder_if.sv
// Bundle of the sampled seven-segment bus and the decoded frame results.
// The decoder holds the slave modport; the display side and the bench hold the master modport.
interface sseg_scan_decoder_if;
  logic [3:0]  an_i;
  logic [6:0]  sseg_i;
  logic        dp_i;
  logic [15:0] digits_o;
  logic [3:0]  dp_o;
  logic [3:0]  blank_o;
  logic        frame_valid_o;
  logic        invalid_o;
  logic        stall_o;

  modport slave (
    input  an_i,
    input  sseg_i,
    input  dp_i,
    output digits_o,
    output dp_o,
    output blank_o,
    output frame_valid_o,
    output invalid_o,
    output stall_o
  );

  modport master (
    output an_i,
    output sseg_i,
    output dp_i,
    input  digits_o,
    input  dp_o,
    input  blank_o,
    input  frame_valid_o,
    input  invalid_o,
    input  stall_o
  );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Samples a multiplexed active-low 4-digit seven-segment bus, decodes each
// stable digit back to hex and publishes complete 4-digit frames.
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                clk_i,
  input logic                rst_ni,
  sseg_scan_decoder_if.slave bus
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_PRE = TW'(TIMEOUT_CYCLES - 1);

  // Input register and the copy of the previous sample used for stability.
  logic [3:0]    smp_an,  prev_an;
  logic [6:0]    smp_seg, prev_seg;
  logic          smp_dp,  prev_dp;
  logic [SW-1:0] stab_cnt, stab_next;
  logic          smp_valid, smp_same, accept;

  // Decode of the registered sample.
  logic [3:0]    dec_val;
  logic          dec_ok, dec_blank;
  logic [1:0]    slot_idx;
  logic [3:0]    slot_mask;
  logic          frame_done;

  // Frame assembly state.
  logic [3:0]    seen;
  logic [15:0]   scr_digits;
  logic [3:0]    scr_dp, scr_blank;
  logic          frame_pend;
  logic [TW-1:0] to_cnt;

  // Registered outputs.
  logic [15:0]   digits_q;
  logic [3:0]    dp_q, blank_q;
  logic          frame_valid_q, invalid_q, stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      smp_an   <= '0;
      smp_seg  <= '0;
      smp_dp   <= 1'b0;
      prev_an  <= '0;
      prev_seg <= '0;
      prev_dp  <= 1'b0;
      stab_cnt <= '0;
    end else begin
      smp_an   <= bus.an_i;
      smp_seg  <= bus.sseg_i;
      smp_dp   <= bus.dp_i;
      prev_an  <= smp_an;
      prev_seg <= smp_seg;
      prev_dp  <= smp_dp;
      stab_cnt <= stab_next;
    end
  end

  // A sample counts only with exactly one anode driven low.
  assign smp_valid = $onehot(~smp_an);
  assign smp_same  = ({smp_an, smp_seg, smp_dp} == {prev_an, prev_seg, prev_dp});

  always_comb begin
    stab_next = SW'(1);
    if (!smp_valid) begin
      stab_next = '0;
    end else if (smp_same && (stab_cnt != '0)) begin
      stab_next = (stab_cnt == STABLE_MAX) ? STABLE_MAX : stab_cnt + SW'(1);
    end
  end

  // Fires only on the step into saturation, so one dwell yields one accept.
  assign accept = smp_valid && (stab_next == STABLE_MAX) && (stab_cnt != STABLE_MAX);

  always_comb begin
    dec_val   = 4'h0;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (smp_seg)
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
      7'b1111111: dec_blank = 1'b1;
      default:    dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    slot_idx  = 2'd0;
    slot_mask = 4'b0000;
    case (smp_an)
      4'b1110: begin slot_idx = 2'd0; slot_mask = 4'b0001; end
      4'b1101: begin slot_idx = 2'd1; slot_mask = 4'b0010; end
      4'b1011: begin slot_idx = 2'd2; slot_mask = 4'b0100; end
      4'b0111: begin slot_idx = 2'd3; slot_mask = 4'b1000; end
      default: begin slot_idx = 2'd0; slot_mask = 4'b0000; end
    endcase
  end

  assign frame_done = accept && dec_ok && ((seen | slot_mask) == 4'b1111);

  // An accept restarts the timeout, so it always wins over an expiring timer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seen       <= '0;
      scr_digits <= '0;
      scr_dp     <= '0;
      scr_blank  <= '0;
      frame_pend <= 1'b0;
      to_cnt     <= '0;
      stall_q    <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      frame_pend <= frame_done;
      invalid_q  <= accept && !dec_ok;
      if (accept) begin
        to_cnt  <= '0;
        stall_q <= 1'b0;
        if (dec_ok) begin
          scr_digits[slot_idx*4 +: 4] <= dec_val;
          scr_dp[slot_idx]            <= ~smp_dp;
          scr_blank[slot_idx]         <= dec_blank;
          seen <= frame_done ? 4'b0000 : (seen | slot_mask);
        end
      end else if (to_cnt != TIMEOUT_MAX) begin
        to_cnt <= to_cnt + TW'(1);
        if (to_cnt == TIMEOUT_PRE) begin
          stall_q <= 1'b1;
          seen    <= '0;
        end
      end
    end
  end

  // frame_valid_o is a one-cycle valid with no ready: a monitor cannot be
  // back-pressured, so the frame is published the edge after completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digits_q      <= '0;
      dp_q          <= '0;
      blank_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= frame_pend;
      if (frame_pend) begin
        digits_q <= scr_digits;
        dp_q     <= scr_dp;
        blank_q  <= scr_blank;
      end
    end
  end

  assign bus.digits_o      = digits_q;
  assign bus.dp_o          = dp_q;
  assign bus.blank_o       = blank_q;
  assign bus.frame_valid_o = frame_valid_q;
  assign bus.invalid_o     = invalid_q;
  assign bus.stall_o       = stall_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed vector table, hand sequences for latency,
// reset and stall, plus randomized dwells checked against a run-length reference model.
module tb_sseg_scan_decoder;
  localparam int S = 4;
  localparam int T = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sseg_scan_decoder_if bus();

  sseg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int fv_cnt   = 0;
  int inv_cnt  = 0;
  logic [23:0] exp_q[$];

  logic [6:0] seg_tab[16];
  logic [11:0] cur_pins;

  // ---------------- reference model ----------------
  int   run_len;
  logic [11:0] last_pins;
  bit   acc_pend;
  logic [11:0] acc_pins;
  bit   pub_pend;
  int   scr_val[4];
  bit   scr_dot[4];
  bit   scr_blk[4];
  bit   m_seen[4];
  int   m_to;
  bit   m_fv, m_inv, m_stall;
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_bl;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int          hold;
    bit          chk;
    logic [15:0] e_dig;
    logic [3:0]  e_dp;
    logic [3:0]  e_bl;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_decode(input logic [6:0] seg, output int val, output bit blank, output bit ok);
    val = 0; blank = 0; ok = 0;
    if (seg == 7'b1111111) begin
      ok = 1; blank = 1;
    end else begin
      for (int i = 0; i < 16; i++) if (seg_tab[i] == seg) begin ok = 1; val = i; end
    end
  endfunction

  task automatic model_reset();
    run_len = 0; last_pins = '0; acc_pend = 0; acc_pins = '0; pub_pend = 0;
    for (int i = 0; i < 4; i++) begin scr_val[i] = 0; scr_dot[i] = 0; scr_blk[i] = 0; m_seen[i] = 0; end
    m_to = 0; m_fv = 0; m_inv = 0; m_stall = 0;
    m_digits = '0; m_dp = '0; m_bl = '0;
    exp_q.delete();
  endtask

  // One clock edge of the model: pins present before edge n form a run;
  // a run of exactly S identical valid vectors is accepted at edge n+1,
  // and a completed frame is published one edge later.
  task automatic model_step();
    int  val, k, cnt;
    bit  blank, ok, all;
    m_fv = 0; m_inv = 0;
    if (pub_pend) begin
      for (int i = 0; i < 4; i++) begin
        m_digits[i*4 +: 4] = 4'(scr_val[i]);
        m_dp[i] = scr_dot[i];
        m_bl[i] = scr_blk[i];
      end
      exp_q.push_back({m_dp, m_bl, m_digits});
      m_fv = 1; pub_pend = 0;
    end
    if (acc_pend) begin
      m_to = 0; m_stall = 0;
      m_decode(acc_pins[7:1], val, blank, ok);
      if (!ok) m_inv = 1;
      else begin
        k = 0;
        for (int i = 0; i < 4; i++) if (acc_pins[8+i] == 1'b0) k = i;
        scr_val[k] = val; scr_dot[k] = !acc_pins[0]; scr_blk[k] = blank; m_seen[k] = 1;
        all = 1;
        for (int i = 0; i < 4; i++) if (!m_seen[i]) all = 0;
        if (all) begin
          pub_pend = 1;
          for (int i = 0; i < 4; i++) m_seen[i] = 0;
        end
      end
    end else if (m_to < T) begin
      m_to++;
      if (m_to == T) begin
        m_stall = 1;
        for (int i = 0; i < 4; i++) m_seen[i] = 0;
      end
    end
    cnt = 0;
    for (int i = 0; i < 4; i++) if (cur_pins[8+i] == 1'b0) cnt++;
    if (cnt != 1) run_len = 0;
    else if (run_len > 0 && cur_pins == last_pins) begin
      if (run_len < 1000) run_len++;
    end else run_len = 1;
    last_pins = cur_pins;
    acc_pend = (run_len == S);
    acc_pins = cur_pins;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_pins(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    bus.an_i = an; bus.sseg_i = seg; bus.dp_i = dp;
    cur_pins = {an, seg, dp};
  endtask

  task automatic tick();
    logic [23:0] e;
    @(posedge clk);
    model_step();
    #1;
    if (bus.frame_valid_o) fv_cnt++;
    if (bus.invalid_o) inv_cnt++;
    chk("frame_valid", 32'(bus.frame_valid_o), 32'(m_fv));
    chk("invalid", 32'(bus.invalid_o), 32'(m_inv));
    chk("stall", 32'(bus.stall_o), 32'(m_stall));
    chk("held_outputs", 32'({bus.dp_o, bus.blank_o, bus.digits_o}), 32'({m_dp, m_bl, m_digits}));
    if (bus.frame_valid_o) begin
      if (exp_q.size() == 0) chk("frame_unexpected", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        chk("frame", 32'({bus.dp_o, bus.blank_o, bus.digits_o}), 32'(e));
      end
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int cycles);
    set_pins(an, seg, dp);
    repeat (cycles) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_digits", 32'(bus.digits_o), 32'(0));
    chk("rst_dp", 32'(bus.dp_o), 32'(0));
    chk("rst_blank", 32'(bus.blank_o), 32'(0));
    chk("rst_fv", 32'(bus.frame_valid_o), 32'(0));
    chk("rst_inv", 32'(bus.invalid_o), 32'(0));
    chk("rst_stall", 32'(bus.stall_o), 32'(0));
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, f0, i0, first;
    logic [3:0] an;
    logic [6:0] seg;
    int r, q, hold;

    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
    seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100; seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;

    vt[0]  = '{4'b1110, 7'b1001111, 1'b1, 8, 1'b0, 16'h0000, 4'h0, 4'h0};
    vt[1]  = '{4'b1101, 7'b0010010, 1'b1, 8, 1'b0, 16'h0000, 4'h0, 4'h0};
    vt[2]  = '{4'b1011, 7'b0000110, 1'b1, 8, 1'b0, 16'h0000, 4'h0, 4'h0};
    vt[3]  = '{4'b1110, 7'b1001111, 1'b1, 8, 1'b0, 16'h0000, 4'h0, 4'h0};
    vt[4]  = '{4'b1101, 7'b0001111, 1'b1, 8, 1'b0, 16'h0000, 4'h0, 4'h0};
    vt[5]  = '{4'b1101, 7'b0000000, 1'b1, 3, 1'b0, 16'h0000, 4'h0, 4'h0};
    vt[6]  = '{4'b1011, 7'b0000110, 1'b1, 8, 1'b0, 16'h0000, 4'h0, 4'h0};
    vt[7]  = '{4'b0111, 7'b1001100, 1'b1, 8, 1'b1, 16'h4371, 4'h0, 4'h0};
    vt[8]  = '{4'b1110, 7'b0000001, 1'b1, 8, 1'b0, 16'h0000, 4'h0, 4'h0};
    vt[9]  = '{4'b1101, 7'b1001111, 1'b1, 8, 1'b0, 16'h0000, 4'h0, 4'h0};
    vt[10] = '{4'b1011, 7'b0010010, 1'b0, 8, 1'b0, 16'h0000, 4'h0, 4'h0};
    vt[11] = '{4'b0111, 7'b1111111, 1'b1, 8, 1'b1, 16'h0210, 4'b0100, 4'b1000};
    vt[12] = '{4'b1110, 7'b1111110, 1'b1, 8, 1'b1, 16'h0210, 4'b0100, 4'b1000};
    vt[13] = '{4'b1100, 7'b0000000, 1'b1, 8, 1'b1, 16'h0210, 4'b0100, 4'b1000};

    model_reset();
    set_pins(4'b1110, 7'b1001111, 1'b1);

    // Reset, then a second reset pulse in the middle of a dwell.
    do_reset();
    tick(); tick();
    do_reset();
    f0 = fv_cnt;
    repeat (S + 4) tick();
    chk("no_frame_after_reset", 32'(fv_cnt - f0), 32'(0));

    // Scan 1,2,3 from the table, then digit 4 by hand to measure latency.
    for (int v = 0; v < 3; v++) drive(vt[v].an, vt[v].seg, vt[v].dp, vt[v].hold);
    f0 = fv_cnt; lat = 0;
    set_pins(4'b0111, 7'b1001100, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.frame_valid_o && lat == 0) lat = i;
    end
    chk("frame_latency", 32'(lat), 32'(S + 2));
    chk("frame_pulses", 32'(fv_cnt - f0), 32'(1));
    chk("scan_digits", 32'(bus.digits_o), 32'h4321);
    chk("scan_dp", 32'(bus.dp_o), 32'(0));
    chk("scan_blank", 32'(bus.blank_o), 32'(0));

    // Glitch, dp/blank, invalid pattern and multi-anode rows.
    i0 = inv_cnt;
    for (int v = 3; v < 12; v++) begin
      drive(vt[v].an, vt[v].seg, vt[v].dp, vt[v].hold);
      if (vt[v].chk) begin
        chk("vec_digits", 32'(bus.digits_o), 32'(vt[v].e_dig));
        chk("vec_dp", 32'(bus.dp_o), 32'(vt[v].e_dp));
        chk("vec_blank", 32'(bus.blank_o), 32'(vt[v].e_bl));
      end
    end
    chk("glitch_no_invalid", 32'(inv_cnt - i0), 32'(0));
    i0 = inv_cnt; f0 = fv_cnt;
    for (int v = 12; v < 14; v++) begin
      drive(vt[v].an, vt[v].seg, vt[v].dp, vt[v].hold);
      if (vt[v].chk) begin
        chk("vec_digits", 32'(bus.digits_o), 32'(vt[v].e_dig));
        chk("vec_dp", 32'(bus.dp_o), 32'(vt[v].e_dp));
        chk("vec_blank", 32'(bus.blank_o), 32'(vt[v].e_bl));
      end
    end
    chk("invalid_pulses", 32'(inv_cnt - i0), 32'(1));
    chk("invalid_no_frame", 32'(fv_cnt - f0), 32'(0));

    // Randomized dwells against the model.
    for (int d = 0; d < 250; d++) begin
      r = $urandom_range(0, 9);
      hold = $urandom_range(1, 9);
      if (r < 8) begin
        an = 4'b1111;
        an[$urandom_range(0, 3)] = 1'b0;
      end else if (r == 8) begin
        an = 4'b1111;
        hold = $urandom_range(1, 80);
      end else an = 4'($urandom_range(0, 15));
      q = $urandom_range(0, 19);
      if (q < 16) seg = seg_tab[q];
      else if (q < 18) seg = 7'b1111111;
      else seg = 7'($urandom_range(0, 127));
      drive(an, seg, 1'($urandom_range(0, 1)), hold);
    end

    // Stall: two digits, then no anode for 70 cycles, then a full scan.
    do_reset();
    drive(4'b1110, 7'b0000001, 1'b1, 8);
    drive(4'b1101, 7'b1001111, 1'b1, 8);
    set_pins(4'b1111, 7'b1111111, 1'b1);
    first = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (bus.stall_o && first == 0) first = i;
    end
    chk("stall_rise", 32'(first), 32'(T - 3));
    chk("stall_level", 32'(bus.stall_o), 32'(1));
    set_pins(4'b1110, 7'b0100100, 1'b1);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (!bus.stall_o && first == 0) first = i;
    end
    chk("stall_clear", 32'(first), 32'(S + 1));
    drive(4'b1101, 7'b0100000, 1'b1, 8);
    drive(4'b1011, 7'b0001111, 1'b1, 8);
    drive(4'b0111, 7'b0000000, 1'b1, 8);
    chk("stall_scan_digits", 32'(bus.digits_o), 32'h8765);

    chk("exp_q_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
